atanh_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one atanh CORDIC core among N_REQ requesters.
- Accepts one fixed-point tanh(a) operand at a time and latches it.
- Fires the core's one-cycle trig, tracks its vld busy window, then returns the result tagged with the requester id.
- Sits between the front-end requesters and the single atanh datapath instance.

---
 rtl/atanh_pkg.sv | 21 ++
 rtl/atanh_arb_if.sv | 30 +++
 rtl/rr_arbiter.sv | 39 +++
 rtl/atanh_arb.sv | 163 ++++++++++++++++
 tb/tb_atanh_arb.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/atanh_pkg.sv
// Shared definitions for the atanh CORDIC arbiter slice: parameter defaults,
// FSM state encoding and fixed-point scale factors.
package atanh_pkg;

  localparam int N_REQ_DEF  = 4;   // requesters sharing the core
  localparam int DW_DEF     = 9;   // operand/result width, signed fixed point
  localparam int TO_CYC_DEF = 64;  // watchdog limit (timeout build only)

  // Fixed-point weights: tanh(a) operand LSB and atanh result LSB (pi/512).
  localparam real TANHA_LSB = 0.00390625;
  localparam real A_LSB     = 0.006135923151543;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_HI,
    WAIT_LO,
    DONE
  } state_t;

endpackage

// File: rtl/atanh_arb_if.sv
// Requester-side request/response bundle of the atanh arbiter.
// master = requester front end, slave = arbiter.
interface atanh_arb_if
  import atanh_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DW    = DW_DEF
) ();

  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]    req_vld;
  logic [N_REQ*DW-1:0] req_tanha;
  logic [N_REQ-1:0]    req_rdy;
  logic                rsp_vld;
  logic [IW-1:0]       rsp_id;
  logic signed [DW-1:0] rsp_a;
  logic                rsp_err;

  modport master (
    output req_vld, req_tanha,
    input  req_rdy, rsp_vld, rsp_id, rsp_a, rsp_err
  );

  modport slave (
    input  req_vld, req_tanha,
    output req_rdy, rsp_vld, rsp_id, rsp_a, rsp_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i,
// wrapping modulo N_REQ. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    gnt_idx_o,
  output logic             any_o
);

  localparam int SW = IW + 1;

  logic [N_REQ-1:0] rot;
  logic [IW-1:0]    off;
  logic [SW-1:0]    sum;

  // Rotate so the pointer sits at bit 0, take the lowest set bit, un-rotate.
  always_comb begin
    // NOTE: every output and temporary gets a default before any branch so no latch is inferred.
    rot       = '0;
    off       = '0;
    sum       = '0;
    gnt_idx_o = '0;
    gnt_o     = '0;
    any_o     = |req_i;
    rot       = N_REQ'({req_i, req_i} >> ptr_i);
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= SW'(N_REQ)) sum = sum - SW'(N_REQ);
    gnt_idx_o = sum[IW-1:0];
    gnt_o     = any_o ? (N_REQ'(1) << gnt_idx_o) : '0;
  end

endmodule

// File: rtl/atanh_arb.sv
// Round-robin arbiter/sequencer sharing one atanh CORDIC core among N_REQ
// requesters: grant, latch operand, pulse core_trig, track the core_vld
// window, return the result tagged with the requester id.
// Optional watchdog: define ATANH_ARB_TIMEOUT_EN.
module atanh_arb
  import atanh_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int DW     = DW_DEF,
  parameter int TO_CYC = TO_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  atanh_arb_if.slave           bus,
  output logic                 core_trig,
  output logic signed [DW-1:0] core_tanha,
  input  logic                 core_vld,
  input  logic signed [DW-1:0] core_a,
  output logic                 busy
);

  localparam int IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("atanh_arb: N_REQ must lie in 2..8");
  end
  if (TO_CYC < 2) begin : g_bad_to
    $error("atanh_arb: TO_CYC must be at least 2");
  end

  state_t               state_q;
  logic [IW-1:0]        ptr_q, id_q, rsp_id_q;
  logic [N_REQ-1:0]     req_rdy_q;
  logic                 rsp_vld_q, core_trig_q, busy_q;
  logic signed [DW-1:0] core_tanha_q, rsp_a_q;

  logic [N_REQ-1:0]     gnt;
  logic [IW-1:0]        gnt_idx, ptr_d;
  logic                 any_req;
  logic signed [DW-1:0] tanha_d;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req_i    (bus.req_vld),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx),
    .any_o    (any_req)
  );

  // Operand of the winning requester and the pointer just past it.
  always_comb begin
    tanha_d = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) tanha_d = bus.req_tanha[k*DW +: DW];
    end
    ptr_d = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
  end

`ifdef ATANH_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYC + 1);
  logic [CW-1:0] cnt_q;
  logic          rsp_err_q;
  logic          to_hit;
  // DONE plus the registered strobe add two cycles, so expiry fires two counts
  // early and rsp_vld lands exactly TO_CYC cycles after the first WAIT_HI cycle.
  assign to_hit      = (cnt_q == CW'(TO_CYC - 2));
  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  // Sequencer FSM with registered pulses, operand latch and response hold.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: there is no storage array here; every register is reset because all outputs must read 0.
      state_q      <= IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      rsp_id_q     <= '0;
      req_rdy_q    <= '0;
      rsp_vld_q    <= 1'b0;
      core_trig_q  <= 1'b0;
      busy_q       <= 1'b0;
      core_tanha_q <= '0;
      rsp_a_q      <= '0;
`ifdef ATANH_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments, so every branch sees the pre-edge register values.
      req_rdy_q   <= '0;
      rsp_vld_q   <= 1'b0;
      core_trig_q <= 1'b0;
`ifdef ATANH_ARB_TIMEOUT_EN
      if (state_q == WAIT_HI || state_q == WAIT_LO) cnt_q <= cnt_q + CW'(1);
`endif
      case (state_q)
        IDLE: begin
          if (any_req) begin
            req_rdy_q    <= gnt;
            core_tanha_q <= tanha_d;
            id_q         <= gnt_idx;
            ptr_q        <= ptr_d;
            busy_q       <= 1'b1;
            state_q      <= TRIG;
          end
        end
        TRIG: begin
          core_trig_q <= 1'b1;
          state_q     <= WAIT_HI;
`ifdef ATANH_ARB_TIMEOUT_EN
          cnt_q       <= '0;
`endif
        end
        WAIT_HI: begin
          if (core_vld) state_q <= WAIT_LO;
`ifdef ATANH_ARB_TIMEOUT_EN
          else if (to_hit) begin
            rsp_a_q   <= '0;
            rsp_id_q  <= id_q;
            rsp_err_q <= 1'b1;
            state_q   <= DONE;
          end
`endif
        end
        WAIT_LO: begin
          if (!core_vld) begin
            rsp_a_q   <= core_a;
            rsp_id_q  <= id_q;
            state_q   <= DONE;
`ifdef ATANH_ARB_TIMEOUT_EN
            rsp_err_q <= 1'b0;
`endif
          end
`ifdef ATANH_ARB_TIMEOUT_EN
          else if (to_hit) begin
            rsp_a_q   <= '0;
            rsp_id_q  <= id_q;
            rsp_err_q <= 1'b1;
            state_q   <= DONE;
          end
`endif
        end
        DONE: begin
          rsp_vld_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_rdy = req_rdy_q;
  assign bus.rsp_vld = rsp_vld_q;
  assign bus.rsp_id  = rsp_id_q;
  assign bus.rsp_a   = rsp_a_q;
  assign core_trig   = core_trig_q;
  assign core_tanha  = core_tanha_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_atanh_arb.sv
// Self-checking bench for atanh_arb: table-driven grant sequences, reset and
// watchdog corner cases, randomized traffic and a full operand sweep against
// a behavioural atanh core. Build with ATANH_ARB_TIMEOUT_EN for the watchdog.
module tb_atanh_arb;
  import atanh_pkg::*;

  localparam int N  = 4;
  localparam int DW = 9;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  atanh_arb_if #(.N_REQ(N), .DW(DW)) bus ();

  logic                 core_trig, core_vld, busy;
  logic signed [DW-1:0] core_tanha, core_a;

  atanh_arb #(.N_REQ(N), .DW(DW), .TO_CYC(TO)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .core_trig (core_trig),
    .core_tanha(core_tanha),
    .core_vld  (core_vld),
    .core_a    (core_a),
    .busy      (busy)
  );

  int errors = 0, checks = 0;
  int ref_ptr = 0;
  int rsp_seen = 0, rsp_expected = 0;
  logic signed [DW-1:0] opnd [N];

  int core_len = 3;
  bit core_stuck = 1'b0;
  bit use_fixed = 1'b0;
  logic signed [DW-1:0] fixed_a = '0;
  int core_cnt;

  // Behavioural atanh: round(atanh(x/256)/A_LSB), saturated to 9-bit signed.
  function automatic logic signed [DW-1:0] ref_atanh(input logic signed [DW-1:0] x);
    real r, a;
    int q;
    if (int'(x) == -256) return -256;
    r = real'(int'(x)) / 256.0;
    a = 0.5 * $ln((1.0 + r) / (1.0 - r)) / A_LSB;
    q = (a >= 0.0) ? $rtoi(a + 0.5) : -$rtoi(-a + 0.5);
    if (q > 255) q = 255;
    if (q < -256) q = -256;
    return DW'(q);
  endfunction

  // Round-robin rule: first requester at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Behavioural core: trig starts a core_len-cycle vld window, result held.
  always @(posedge clk) begin
    if (!rstn) begin
      core_vld <= 1'b0;
      core_a   <= '0;
      core_cnt <= 0;
    end else if (core_trig) begin
      core_vld <= 1'b1;
      core_a   <= use_fixed ? fixed_a : ref_atanh(core_tanha);
      core_cnt <= core_len - 1;
    end else if (core_vld && !core_stuck) begin
      if (core_cnt == 0) core_vld <= 1'b0;
      else core_cnt <= core_cnt - 1;
    end
  end

  always @(negedge clk) if (bus.rsp_vld) rsp_seen++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_ops();
    for (int k = 0; k < N; k++) bus.req_tanha[k*DW +: DW] = opnd[k];
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_rdy"},    bus.req_rdy, 0);
    check({tag, "_rsp_vld"},    bus.rsp_vld, 0);
    check({tag, "_rsp_id"},     bus.rsp_id, 0);
    check({tag, "_rsp_a"},      bus.rsp_a, 0);
    check({tag, "_rsp_err"},    bus.rsp_err, 0);
    check({tag, "_core_trig"},  core_trig, 0);
    check({tag, "_core_tanha"}, core_tanha, 0);
    check({tag, "_busy"},       busy, 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.req_vld = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rstn = 1'b1;
    ref_ptr = 0;
  endtask

  // One transaction: grant of exp_id, trig next cycle, response at len+4.
  task automatic txn(input int exp_id, input int len, input logic signed [DW-1:0] exp_a);
    bit got;
    int lat;
    logic signed [DW-1:0] op;
    op = opnd[exp_id];
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = (bus.req_rdy != '0);
    end
    check("grant_seen", got, 1);
    if (!got) begin
      bus.req_vld = '0;
      return;
    end
    check("req_rdy", bus.req_rdy, 1 << exp_id);
    ref_ptr = (exp_id + 1) % N;
    bus.req_vld[exp_id] = 1'b0;
    @(negedge clk);
    check("core_trig", core_trig, 1);
    check("core_tanha", core_tanha, op);
    check("busy", busy, 1);
    got = 1'b0;
    for (int i = 2; i < len + 40 && !got; i++) begin
      @(negedge clk);
      if (i == 2) check("trig_pulse", core_trig, 0);
      if (bus.rsp_vld) begin
        got = 1'b1;
        lat = i;
      end
    end
    check("rsp_seen", got, 1);
    if (!got) return;
    rsp_expected++;
    check("latency", lat, len + 4);
    check("rsp_id", bus.rsp_id, exp_id);
    check("rsp_a", bus.rsp_a, exp_a);
    check("rsp_err", bus.rsp_err, 0);
  endtask

  typedef struct {
    bit         do_rst;
    logic [N-1:0] mask;
    int         exp_id;
    int         len;
  } vec_t;

  vec_t tbl [14];

  initial begin
    bit got;
    int cnt;
    real maxerr, at, e;
    int in_range;

    tbl[0]  = '{1'b1, 4'b1111, 0, 3};
    tbl[1]  = '{1'b0, 4'b1111, 1, 1};
    tbl[2]  = '{1'b0, 4'b1111, 2, 2};
    tbl[3]  = '{1'b0, 4'b1111, 3, 4};
    tbl[4]  = '{1'b0, 4'b1111, 0, 3};
    tbl[5]  = '{1'b0, 4'b1111, 1, 1};
    tbl[6]  = '{1'b0, 4'b1010, 3, 2};
    tbl[7]  = '{1'b0, 4'b1010, 1, 2};
    tbl[8]  = '{1'b0, 4'b0001, 0, 1};
    tbl[9]  = '{1'b0, 4'b0100, 2, 5};
    tbl[10] = '{1'b0, 4'b0011, 0, 2};
    tbl[11] = '{1'b0, 4'b0110, 1, 3};
    tbl[12] = '{1'b1, 4'b0110, 1, 3};
    tbl[13] = '{1'b0, 4'b1001, 3, 2};

    rstn = 1'b0;
    bus.req_vld = '0;
    bus.req_tanha = '0;
    repeat (2) @(negedge clk);
    check_zero("por");
    rstn = 1'b1;

    // Single request from requester 0 with a fixed core answer.
    opnd[0] = -256; opnd[1] = 0; opnd[2] = 0; opnd[3] = 0;
    set_ops();
    use_fixed = 1'b1;
    fixed_a = -100;
    core_len = 3;
    bus.req_vld = 4'b0001;
    txn(0, 3, -100);
    @(negedge clk);
    check("hold_rsp_vld", bus.rsp_vld, 0);
    check("hold_rsp_a", bus.rsp_a, -100);
    check("hold_busy", busy, 0);
    use_fixed = 1'b0;

    // Grant-order table: fairness, wrap-around, pointer reset.
    opnd[0] = 10; opnd[1] = 20; opnd[2] = 30; opnd[3] = 40;
    set_ops();
    for (int v = 0; v < 14; v++) begin
      if (tbl[v].do_rst) do_reset();
      core_len = tbl[v].len;
      bus.req_vld = tbl[v].mask;
      txn(tbl[v].exp_id, tbl[v].len, ref_atanh(opnd[tbl[v].exp_id]));
    end

    // Reset while the core window is open (WAIT_LO): no response, clean restart.
    opnd[2] = 77;
    set_ops();
    core_len = 10;
    bus.req_vld = 4'b0100;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = (bus.req_rdy != '0);
    end
    check("midrst_grant", got, 1);
    bus.req_vld = '0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = core_vld;
    end
    check("midrst_core_vld", got, 1);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    rstn = 1'b1;
    ref_ptr = 0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_vld) cnt++;
    end
    check("midrst_no_rsp", cnt, 0);
    core_len = 2;
    bus.req_vld = 4'b0100;
    txn(2, 2, ref_atanh(opnd[2]));

    // Randomized traffic against the round-robin model.
    for (int r = 0; r < 40; r++) begin
      logic [N-1:0] m;
      int g;
      m = N'($urandom_range(1, 15));
      for (int k = 0; k < N; k++) opnd[k] = DW'($urandom_range(0, 511));
      set_ops();
      core_len = $urandom_range(1, 6);
      g = pick(m, ref_ptr);
      bus.req_vld = m;
      txn(g, core_len, ref_atanh(opnd[g]));
    end

    // Full operand sweep through requester 0.
    maxerr = 0.0;
    in_range = 0;
    for (int x = -256; x <= 255; x++) begin
      opnd[0] = DW'(x);
      set_ops();
      core_len = $urandom_range(1, 4);
      bus.req_vld = 4'b0001;
      txn(pick(4'b0001, ref_ptr), core_len, ref_atanh(opnd[0]));
      if (x > -256) begin
        at = 0.5 * $ln((1.0 + x / 256.0) / (1.0 - x / 256.0));
        if (at <= 255.0 * A_LSB && at >= -255.0 * A_LSB) begin
          e = real'(int'(bus.rsp_a)) * A_LSB - at;
          if (e < 0.0) e = -e;
          if (e > maxerr) maxerr = e;
          in_range++;
        end
      end
    end
    $display("sweep: %0d in-range points, max |err| = %f", in_range, maxerr);
    check("sweep_max_err_ok", (in_range > 0 && maxerr <= 0.5 * A_LSB + 1.0e-9) ? 1 : 0, 1);

    // Core stuck busy: watchdog response, or indefinite wait without it.
    opnd[1] = 5;
    set_ops();
    core_stuck = 1'b1;
    core_len = 3;
    bus.req_vld = 4'b0010;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = (bus.req_rdy != '0);
    end
    check("stuck_grant", got, 1);
    bus.req_vld = '0;
    @(negedge clk);
    check("stuck_trig", core_trig, 1);
`ifdef ATANH_ARB_TIMEOUT_EN
    got = 1'b0;
    cnt = -1;
    for (int i = 1; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.rsp_vld) begin
        got = 1'b1;
        cnt = i;
      end
    end
    check("to_rsp_seen", got, 1);
    if (got) rsp_expected++;
    check("to_latency", cnt, TO);
    check("to_rsp_err", bus.rsp_err, 1);
    check("to_rsp_a", bus.rsp_a, 0);
    check("to_rsp_id", bus.rsp_id, 1);
`else
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy || bus.rsp_vld) cnt++;
    end
    check("stuck_busy_held", cnt, 0);
`endif
    core_stuck = 1'b0;
    do_reset();

    @(negedge clk);
    check("rsp_count", rsp_seen, rsp_expected);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
